// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Sequencer states, one per phase of a multicycle fetch
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    READ   = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    FAULT  = 3'd5
  } fetch_state_t;

  // Fault codes reported on fault_code
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  // Polarity of rw for a memory read
  localparam logic RW_READ = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_reg
// Brief    : Program counter with companion next-PC register. Supports a
//            sequential advance and an absolute load; all sums wrap modulo
//            2^ADDR_W.
// Revision : 1.0 - initial release
// ============================================================================
module pc_reg #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                INSTR_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

  // PC/NPC update; load has priority though the sequencer never asserts both
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= RESET_VEC;
      npc <= RESET_VEC + STEP;
    end else if (load) begin
      pc  <= load_value;
      npc <= load_value + STEP;
    end else if (advance) begin
      pc  <= npc;
      npc <= npc + STEP;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Multicycle instruction-fetch sequencer. Drives MAR load and the
//            MOC read handshake, captures the instruction register, hands the
//            instruction to execute control and handles redirects, memory
//            time-out and sticky faults. All outputs are Moore-style.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                INSTR_BYTES = 4,
  parameter int                MOC_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mar_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              rw,
  input  logic              moc,
  input  logic [31:0]       mem_data,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              exec_done,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int               CNT_W     = $clog2(MOC_TIMEOUT + 1);
  localparam int               ALIGN_W   = $clog2(INSTR_BYTES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MOC_TIMEOUT);

  fetch_state_t     state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next, wait_cnt_inc;
  logic [1:0]       code_next;
  logic             ir_load, pc_advance, pc_load, misaligned;

  assign wait_cnt_inc = wait_cnt + CNT_W'(1);

  // A redirect target is misaligned when any sub-instruction address bit is set
  generate
    if (ALIGN_W == 0) begin : g_align_none
      assign misaligned = 1'b0;
    end else begin : g_align_chk
      assign misaligned = |redirect_target[ALIGN_W-1:0];
    end
  endgenerate

  pc_reg #(
    .ADDR_W      (ADDR_W),
    .RESET_VEC   (RESET_VEC),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .advance    (pc_advance),
    .load       (pc_load),
    .load_value (redirect_target),
    .pc         (pc),
    .npc        (npc)
  );

  // State, wait counter, instruction register and fault code registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      ir         <= '0;
      fault_code <= FAULT_NONE;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      fault_code <= code_next;
      if (ir_load) begin
        ir <= mem_data;
      end
    end
  end

  // Next-state logic and datapath control strobes
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    code_next     = fault_code;
    ir_load       = 1'b0;
    pc_advance    = 1'b0;
    pc_load       = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        // Counter clears as READ is entered; moc here is deliberately ignored
        wait_cnt_next = '0;
        state_next    = READ;
      end
      READ: begin
        // moc takes priority over a time-out occurring in the same cycle
        if (moc) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end else if (wait_cnt_inc == CNT_LIMIT) begin
          state_next = FAULT;
          code_next  = FAULT_TIMEOUT;
        end else begin
          wait_cnt_next = wait_cnt_inc;
        end
      end
      DECODE: begin
        pc_advance = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        if (exec_done) begin
          if (redirect_valid && misaligned) begin
            state_next = FAULT;
            code_next  = FAULT_MISALIGN;
          end else begin
            pc_load    = redirect_valid;
            state_next = run ? ADDR : IDLE;
          end
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mar_load = (state == ADDR);
  assign mem_en   = (state == READ);
  assign rw       = (state == READ) ? RW_READ : ~RW_READ;
  assign ir_valid = (state == DECODE);
  assign fault    = (state == FAULT);
  assign mem_addr = pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench for fetch_sequencer using a transaction-level
//            reference model (expected PC/NPC, fetch latency, fault outcome).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset, run, moc, exec_done, redirect_valid;
  logic [31:0]   mem_data;
  logic [AW-1:0] redirect_target;
  logic          mar_load, mem_en, rw, ir_valid, fault;
  logic [AW-1:0] mem_addr, pc, npc;
  logic [31:0]   ir;
  logic [1:0]    fault_code;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [AW-1:0] exp_pc, exp_npc;
  bit            at_addr;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W      (AW),
    .RESET_VEC   (32'h0),
    .INSTR_BYTES (4),
    .MOC_TIMEOUT (15)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .mar_load        (mar_load),
    .mem_addr        (mem_addr),
    .mem_en          (mem_en),
    .rw              (rw),
    .moc             (moc),
    .mem_data        (mem_data),
    .ir              (ir),
    .ir_valid        (ir_valid),
    .exec_done       (exec_done),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .npc             (npc),
    .fault           (fault),
    .fault_code      (fault_code)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; moc = 1'b0; exec_done = 1'b0;
    redirect_valid = 1'b0; mem_data = '0; redirect_target = '0;
    tick();
    reset   = 1'b0;
    exp_pc  = 32'h0;
    exp_npc = 32'h4;
    at_addr = 1'b0;
    check("rst_pc", pc, exp_pc);
    check("rst_npc", npc, exp_npc);
    check("rst_ir", ir, 32'h0);
    check("rst_outs", {28'h0, mar_load, mem_en, rw, ir_valid}, 32'h0);
    check("rst_fault", {29'h0, fault, fault_code}, 32'h0);
  endtask

  // One complete fetch: READ lasts delay+1 cycles, EXEC waits hold cycles,
  // then exec_done with the given redirect and run level.
  task automatic fetch(input int delay, input logic [31:0] data, input bit redir,
                       input logic [AW-1:0] tgt, input bit nrun, input int hold);
    int idle_n;
    idle_n = $urandom_range(0, 2);
    if (!at_addr) begin
      for (int k = 0; k < idle_n; k++) begin
        run = 1'b0; moc = 1'($urandom);
        tick();
        check("idle_mar", {31'h0, mar_load}, 32'h0);
        check("idle_pc", pc, exp_pc);
      end
      run = 1'b1;
      tick();
    end
    check("addr_mar", {31'h0, mar_load}, 32'h1);
    check("addr_mem_addr", mem_addr, exp_pc);
    check("addr_mem_en", {31'h0, mem_en}, 32'h0);
    run = 1'($urandom); moc = 1'($urandom); mem_data = $urandom;
    tick();
    for (int i = 0; i <= delay; i++) begin
      check("read_en_rw", {30'h0, mem_en, rw}, 32'h3);
      check("read_no_irv", {30'h0, ir_valid, fault}, 32'h0);
      run = 1'($urandom);
      if (i == delay) begin
        moc = 1'b1; mem_data = data;
      end else begin
        moc = 1'b0; mem_data = $urandom;
      end
      tick();
    end
    moc = 1'b0; mem_data = $urandom;
    check("dec_irv", {31'h0, ir_valid}, 32'h1);
    check("dec_ir", ir, data);
    check("dec_mem_en", {31'h0, mem_en}, 32'h0);
    exp_pc  = exp_npc;
    exp_npc = exp_npc + 32'h4;
    exec_done = 1'b0; redirect_valid = 1'($urandom); redirect_target = $urandom;
    tick();
    check("exec_pc", pc, exp_pc);
    check("exec_npc", npc, exp_npc);
    check("exec_irv", {31'h0, ir_valid}, 32'h0);
    for (int h = 0; h < hold; h++) begin
      redirect_valid = 1'($urandom); redirect_target = $urandom; run = 1'($urandom);
      tick();
      check("exec_hold_pc", pc, exp_pc);
      check("exec_hold_mar", {31'h0, mar_load}, 32'h0);
    end
    exec_done = 1'b1; redirect_valid = redir; redirect_target = tgt; run = nrun;
    tick();
    exec_done = 1'b0; redirect_valid = 1'b0;
    if (redir && (tgt[1:0] != 2'b00)) begin
      check("mis_fault", {29'h0, fault, fault_code}, 32'h6);
      check("mis_pc", pc, exp_pc);
      check("mis_mem_en", {31'h0, mem_en}, 32'h0);
      at_addr = 1'b0;
    end else begin
      if (redir) begin
        exp_pc  = tgt;
        exp_npc = tgt + 32'h4;
      end
      check("next_pc", pc, exp_pc);
      check("next_npc", npc, exp_npc);
      check("next_mar", {31'h0, mar_load}, {31'h0, nrun});
      check("next_fault", {31'h0, fault}, 32'h0);
      at_addr = nrun;
    end
  endtask

  initial begin
    do_reset();

    // Minimum-latency fetch with the reference instruction
    fetch(0, 32'h2002000A, 1'b0, '0, 1'b1, 0);
    // Delayed moc and the longest delay that still beats the time-out
    fetch(5, $urandom, 1'b0, '0, 1'b1, 1);
    fetch(14, $urandom, 1'b0, '0, 1'b0, 2);
    // Aligned redirect, then a fetch from the redirected address
    fetch(0, $urandom, 1'b1, 32'h100, 1'b1, 0);
    fetch(1, $urandom, 1'b0, '0, 1'b1, 0);

    // Random traffic: delays, redirects, stalls and run gaps
    for (int t = 0; t < 25; t++) begin
      fetch($urandom_range(0, 14), $urandom, ($urandom_range(0, 3) == 0),
            $urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom_range(0, 3));
    end

    // Reset in the middle of READ while moc is high
    if (!at_addr) begin
      run = 1'b1;
      tick();
    end
    tick();
    check("midrd_mem_en", {31'h0, mem_en}, 32'h1);
    moc = 1'b1; mem_data = 32'hDEADBEEF; reset = 1'b1;
    tick();
    check("midrd_ir", ir, 32'h0);
    check("midrd_outs", {28'h0, mar_load, mem_en, ir_valid, fault}, 32'h0);
    check("midrd_pc", pc, 32'h0);
    check("midrd_npc", npc, 32'h4);
    reset = 1'b0; moc = 1'b0; run = 1'b0;
    tick();
    check("midrd_idle", {31'h0, mar_load}, 32'h0);

    // Address wrap past the top of the address space
    do_reset();
    fetch(0, $urandom, 1'b1, 32'hFFFF_FFF8, 1'b1, 0);
    fetch(2, $urandom, 1'b0, '0, 1'b1, 0);
    check("wrap_npc0", npc, 32'h0);
    fetch(0, $urandom, 1'b0, '0, 1'b1, 0);
    check("wrap_npc4", npc, 32'h4);

    // Misaligned redirect faults and the fault is sticky
    fetch(1, $urandom, 1'b1, 32'h102, 1'b1, 0);
    for (int k = 0; k < 4; k++) begin
      run = 1'b1; moc = 1'($urandom); exec_done = 1'($urandom);
      tick();
      check("mis_sticky", {29'h0, fault, fault_code}, 32'h6);
      check("mis_sticky_pc", pc, exp_pc);
      check("mis_sticky_bus", {30'h0, mar_load, mem_en}, 32'h0);
    end
    exec_done = 1'b0;

    // MOC time-out after exactly 15 READ cycles
    do_reset();
    run = 1'b1;
    tick();
    check("to_mar", {31'h0, mar_load}, 32'h1);
    run = 1'($urandom); moc = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      check("to_read", {29'h0, mem_en, rw, fault}, 32'h6);
      moc = 1'b0;
      tick();
    end
    check("to_fault", {29'h0, fault, fault_code}, 32'h5);
    check("to_mem_en", {31'h0, mem_en}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      run = 1'b1; moc = 1'($urandom);
      tick();
      check("to_sticky", {29'h0, fault, fault_code}, 32'h5);
      check("to_sticky_bus", {30'h0, mar_load, mem_en}, 32'h0);
    end

    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
